// File: rtl/ltmr_pipe_scrub.sv
// ltmr_pipe_scrub: local-TMR pipeline register slice.
// STAGES stages, three replicas each, with a bitwise 2-of-3 voter per stage.
// Voted values feed the next stage. When the slice holds, each stage reloads
// its own vote, which scrubs single-replica upsets. Also provides per-stage
// mismatch flags, a saturating error counter and a fault-injection port.
module ltmr_pipe_scrub #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 1,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned SW    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q,
    input  logic              inj_valid,
    input  logic [SW-1:0]     inj_stage,
    input  logic [1:0]        inj_copy,
    input  logic [WIDTH-1:0]  inj_mask,
    input  logic              err_clear,
    output logic [STAGES-1:0] err_stage,
    output logic              err_any,
    output logic [CNT_W-1:0]  err_count
);

    // Replica registers and their next-state values
    logic [WIDTH-1:0] r0_q [STAGES];
    logic [WIDTH-1:0] r1_q [STAGES];
    logic [WIDTH-1:0] r2_q [STAGES];
    logic [WIDTH-1:0] r0_d [STAGES];
    logic [WIDTH-1:0] r1_d [STAGES];
    logic [WIDTH-1:0] r2_d [STAGES];

    // Per-stage vote, stage input and next value before injection
    logic [WIDTH-1:0] vote_c  [STAGES];
    logic [WIDTH-1:0] stg_in_c[STAGES];
    logic [WIDTH-1:0] nxt_c   [STAGES];

    logic [STAGES-1:0] mis_c;
    logic [STAGES-1:0] err_stage_q;
    logic [CNT_W-1:0]  err_count_q;
    logic [CNT_W-1:0]  err_count_d;
    logic              inj_ok_c;

    // Bitwise 2-of-3 vote and replica disagreement per stage
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            vote_c[s] = (r0_q[s] & r1_q[s]) | (r1_q[s] & r2_q[s]) | (r2_q[s] & r0_q[s]);
            mis_c[s]  = (r0_q[s] != r1_q[s]) || (r1_q[s] != r2_q[s]);
        end
    end

    // Stage inputs: external data into stage 0, previous stage's vote elsewhere
    always_comb begin
        stg_in_c[0] = d;
        for (int s = 1; s < STAGES; s++) begin
            stg_in_c[s] = vote_c[s-1];
        end
    end

    // Replica next state: advance or scrub, then XOR the injection mask into one replica
    always_comb begin
        inj_ok_c = inj_valid && (inj_copy != 2'd3) && (32'(inj_stage) < STAGES);
        for (int s = 0; s < STAGES; s++) begin
            nxt_c[s] = en ? stg_in_c[s] : vote_c[s];
            r0_d[s]  = nxt_c[s];
            r1_d[s]  = nxt_c[s];
            r2_d[s]  = nxt_c[s];
            if (inj_ok_c && (inj_stage == SW'(s))) begin
                case (inj_copy)
                    2'd0:    r0_d[s] = nxt_c[s] ^ inj_mask;
                    2'd1:    r1_d[s] = nxt_c[s] ^ inj_mask;
                    2'd2:    r2_d[s] = nxt_c[s] ^ inj_mask;
                    default: ;
                endcase
            end
        end
    end

    // Error counter: clear has priority, otherwise saturating increment on any mismatch
    always_comb begin
        err_count_d = err_count_q;
        if (err_clear) begin
            err_count_d = '0;
        end else if ((|mis_c) && !(&err_count_q)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r0_q[s] <= '0;
                r1_q[s] <= '0;
                r2_q[s] <= '0;
            end
            err_stage_q <= '0;
            err_count_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                r0_q[s] <= r0_d[s];
                r1_q[s] <= r1_d[s];
                r2_q[s] <= r2_d[s];
            end
            err_stage_q <= mis_c;
            err_count_q <= err_count_d;
        end
    end

    assign q         = vote_c[STAGES-1];
    assign err_stage = err_stage_q;
    assign err_any   = |err_stage_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ltmr_pipe_scrub.sv
// Directed self-checking bench for ltmr_pipe_scrub (WIDTH=8, STAGES=3).
// u0 uses CNT_W=8, u1 uses CNT_W=2 for the saturation scenario.
module tb_ltmr_pipe_scrub;

    logic       clk;
    int         passed;
    int         total;

    // u0 stimulus and observation
    logic       rst0, en0, inj_valid0, err_clear0;
    logic [7:0] d0, inj_mask0, q0, cnt0;
    logic [1:0] inj_stage0, inj_copy0;
    logic [2:0] es0;
    logic       any0;

    // u1 stimulus and observation
    logic       rst1, en1, inj_valid1, err_clear1;
    logic [7:0] d1, inj_mask1, q1;
    logic [1:0] inj_stage1, inj_copy1, cnt1;
    logic [2:0] es1;
    logic       any1;

    ltmr_pipe_scrub #(.WIDTH(8), .STAGES(3), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst0), .en(en0), .d(d0), .q(q0),
        .inj_valid(inj_valid0), .inj_stage(inj_stage0), .inj_copy(inj_copy0),
        .inj_mask(inj_mask0), .err_clear(err_clear0),
        .err_stage(es0), .err_any(any0), .err_count(cnt0)
    );

    ltmr_pipe_scrub #(.WIDTH(8), .STAGES(3), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst1), .en(en1), .d(d1), .q(q1),
        .inj_valid(inj_valid1), .inj_stage(inj_stage1), .inj_copy(inj_copy1),
        .inj_mask(inj_mask1), .err_clear(err_clear1),
        .err_stage(es1), .err_any(any1), .err_count(cnt1)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic no_inj0();
        inj_valid0 = 1'b0;
        inj_stage0 = 2'd0;
        inj_copy0  = 2'd3;
        inj_mask0  = 8'h00;
    endtask

    initial begin
        clk = 1'b0;
        passed = 0;
        total = 0;
        rst0 = 1'b1; en0 = 1'b0; d0 = 8'h00; err_clear0 = 1'b0;
        no_inj0();
        rst1 = 1'b1; en1 = 1'b0; d1 = 8'h00; err_clear1 = 1'b0;
        inj_valid1 = 1'b0; inj_stage1 = 2'd0; inj_copy1 = 2'd3; inj_mask1 = 8'h00;

        // Reset state
        tick();
        check("rst_q",     32'(q0),   32'h0);
        check("rst_es",    32'(es0),  32'h0);
        check("rst_any",   32'(any0), 32'h0);
        check("rst_cnt",   32'(cnt0), 32'h0);

        // Streaming latency: d at edge k appears on q after edge k+2
        rst0 = 1'b0; en0 = 1'b1;
        d0 = 8'h11; tick();
        check("lat_e1",    32'(q0),   32'h0);
        d0 = 8'h22; tick();
        check("lat_e2",    32'(q0),   32'h0);
        d0 = 8'h33; tick();
        check("stream_11", 32'(q0),   32'h11);
        d0 = 8'h44; tick();
        check("stream_22", 32'(q0),   32'h22);
        d0 = 8'hA5; tick();
        check("stream_33", 32'(q0),   32'h33);
        tick();
        tick();
        check("fill_a5",   32'(q0),   32'hA5);
        check("clean_any", 32'(any0), 32'h0);
        check("clean_cnt", 32'(cnt0), 32'h0);

        // Hold and scrub: upset stage 1 replica 2
        en0 = 1'b0;
        inj_valid0 = 1'b1; inj_stage0 = 2'd1; inj_copy0 = 2'd2; inj_mask0 = 8'h0F;
        tick();
        no_inj0();
        check("hold_q0",   32'(q0),   32'hA5);
        check("hold_es0",  32'(es0),  32'h0);
        tick();
        check("hold_q1",   32'(q0),   32'hA5);
        check("hold_es1",  32'(es0),  32'h2);
        check("hold_any1", 32'(any0), 32'h1);
        check("hold_cnt1", 32'(cnt0), 32'h1);
        tick();
        check("scrub_es",  32'(es0),  32'h0);
        check("scrub_cnt", 32'(cnt0), 32'h1);
        check("scrub_q",   32'(q0),   32'hA5);

        // Streaming with upset on stage 0 replica 0
        en0 = 1'b1;
        d0 = 8'h01;
        inj_valid0 = 1'b1; inj_stage0 = 2'd0; inj_copy0 = 2'd0; inj_mask0 = 8'hFF;
        tick();
        no_inj0();
        check("sinj_q1",   32'(q0),   32'hA5);
        d0 = 8'h02; tick();
        check("sinj_q2",   32'(q0),   32'hA5);
        check("sinj_es",   32'(es0),  32'h1);
        check("sinj_cnt",  32'(cnt0), 32'h2);
        d0 = 8'h03; tick();
        check("sinj_q3",   32'(q0),   32'h01);
        d0 = 8'h04; tick();
        check("sinj_q4",   32'(q0),   32'h02);
        check("sinj_es2",  32'(es0),  32'h0);
        check("sinj_cnt2", 32'(cnt0), 32'h2);

        // Ignored injections: copy 3, then out-of-range stage 3
        d0 = 8'h05;
        inj_valid0 = 1'b1; inj_stage0 = 2'd1; inj_copy0 = 2'd3; inj_mask0 = 8'hFF;
        tick();
        check("nop_q5",    32'(q0),   32'h03);
        d0 = 8'h06;
        inj_valid0 = 1'b1; inj_stage0 = 2'd3; inj_copy0 = 2'd0; inj_mask0 = 8'hFF;
        tick();
        no_inj0();
        check("nop_q6",    32'(q0),   32'h04);
        d0 = 8'h07; tick();
        check("nop_q7",    32'(q0),   32'h05);
        check("nop_any",   32'(any0), 32'h0);
        check("nop_cnt",   32'(cnt0), 32'h2);
        d0 = 8'h08; tick();
        check("nop_q8",    32'(q0),   32'h06);
        check("nop_cnt2",  32'(cnt0), 32'h2);

        // Reset mid-stream with injection pending; then refill
        d0 = 8'h77; rst0 = 1'b1;
        inj_valid0 = 1'b1; inj_stage0 = 2'd0; inj_copy0 = 2'd1; inj_mask0 = 8'hFF;
        tick();
        no_inj0();
        check("mrst_q",    32'(q0),   32'h0);
        check("mrst_es",   32'(es0),  32'h0);
        check("mrst_any",  32'(any0), 32'h0);
        check("mrst_cnt",  32'(cnt0), 32'h0);
        rst0 = 1'b0; d0 = 8'h99; tick();
        check("refill_1",  32'(q0),   32'h0);
        d0 = 8'h9A; tick();
        check("refill_2",  32'(q0),   32'h0);
        d0 = 8'h9B; tick();
        check("refill_3",  32'(q0),   32'h99);
        check("refill_es", 32'(es0),  32'h0);

        // u1: saturation with CNT_W=2, injections every other cycle while holding
        rst1 = 1'b0; en1 = 1'b0;
        inj_stage1 = 2'd0; inj_copy1 = 2'd0; inj_mask1 = 8'h01;
        for (int k = 0; k < 4; k++) begin
            inj_valid1 = 1'b1;
            tick();
            inj_valid1 = 1'b0;
            tick();
        end
        check("sat_cnt",   32'(cnt1), 32'h3);
        check("sat_q",     32'(q1),   32'h0);
        // Fifth injection together with clear
        inj_valid1 = 1'b1; err_clear1 = 1'b1;
        tick();
        inj_valid1 = 1'b0; err_clear1 = 1'b0;
        check("clr_cnt",   32'(cnt1), 32'h0);
        tick();
        check("post_clr",  32'(cnt1), 32'h1);
        // Clear on a cycle where an increment would also happen
        inj_valid1 = 1'b1;
        tick();
        inj_valid1 = 1'b0; err_clear1 = 1'b1;
        tick();
        err_clear1 = 1'b0;
        check("clr_wins",  32'(cnt1), 32'h0);
        check("clr_es",    32'(es1),  32'h1);
        check("clr_any",   32'(any1), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
